// File: rtl/ltc2308_responder.sv
// ltc2308_responder
// Device end of the DE1-SoC LTC2308 SPI link. The controller's CS_N, SCLK
// and DIN pins are oversampled on the system clock. Each frame shifts out
// the conversion latched at the end of the previous frame. The config word
// captured from DIN selects which of eight parallel channel inputs becomes
// the next conversion, so the scope path can run in loopback without the
// physical ADC.

module ltc2308_responder #(
   parameter int                  SYNC_STAGES = 2,
   parameter int                  DATA_W      = 12,
   parameter int                  CFG_BITS    = 6,
   parameter logic [CFG_BITS-1:0] RESET_CFG   = 6'b100010
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  adc_cs_n,
   input  logic                  adc_sclk,
   input  logic                  adc_din,
   output logic                  adc_dout,
   input  logic [8*DATA_W-1:0]   ch_data,
   output logic [CFG_BITS-1:0]   cfg_word,
   output logic                  cfg_valid,
   output logic                  frame_error,
   output logic [15:0]           frame_count
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_CFG  = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Config word layout: [5]=S/D [4]=O/S [3]=S1 [2]=S0 [1]=UNI [0]=SLP
   localparam int SD_B  = 5;
   localparam int OS_B  = 4;
   localparam int S1_B  = 3;
   localparam int S0_B  = 2;
   localparam int UNI_B = 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;

   // ------------------------------------------------------------------
   // Pin synchronisers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] din_sync_q;
   logic                   cs_prev_q;
   logic                   sclk_prev_q;

   logic cs_s;
   logic sclk_s;
   logic din_s;
   logic cs_fall;
   logic cs_rise;
   logic sclk_rise;
   logic sclk_fall;

   // Shift the SPI pins through the synchroniser chains and keep one
   // delayed copy of CS_N/SCLK for edge detection.
   // The CS_N chain resets low. If reset is released while CS_N is still
   // low, no falling edge is seen, so a frame cut short by reset cannot
   // restart until the controller raises CS_N and lowers it again.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cs_sync_q   <= '0;
         sclk_sync_q <= '0;
         din_sync_q  <= '0;
         cs_prev_q   <= 1'b0;
         sclk_prev_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // stage samples the value its predecessor held before this edge.
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
         din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], adc_din};
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   // Decode pin edges from the last synchroniser stage and its delayed copy.
   always_comb begin
      cs_s      = cs_sync_q[SYNC_STAGES-1];
      sclk_s    = sclk_sync_q[SYNC_STAGES-1];
      din_s     = din_sync_q[SYNC_STAGES-1];
      cs_fall   =  cs_prev_q   & ~cs_s;
      cs_rise   = ~cs_prev_q   &  cs_s;
      sclk_rise = ~sclk_prev_q &  sclk_s;
      sclk_fall =  sclk_prev_q & ~sclk_s;
   end

   // ------------------------------------------------------------------
   // Channel selection from the config received in this frame
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] ch_arr [8];

   for (genvar n = 0; n < 8; n++) begin : g_ch
      assign ch_arr[n] = ch_data[n*DATA_W +: DATA_W];
   end

   logic [CFG_BITS-1:0] cfg_shift_q;
   logic [2:0]          sel_ch;
   logic                sel_ok;
   logic [DATA_W-1:0]   conv_new;

   // Map {S1,S0,O/S} to a channel number. Differential and bipolar modes
   // are not modelled and convert as zero.
   always_comb begin
      sel_ch   = {cfg_shift_q[S1_B], cfg_shift_q[S0_B], cfg_shift_q[OS_B]};
      sel_ok   = cfg_shift_q[SD_B] & cfg_shift_q[UNI_B];
      conv_new = sel_ok ? ch_arr[sel_ch] : '0;
   end

   // ------------------------------------------------------------------
   // Frame state machine
   // ------------------------------------------------------------------
   logic [1:0]          state_q,       state_d;
   logic [DATA_W-1:0]   shift_q,       shift_d;
   logic [CNT_W-1:0]    bit_cnt_q,     bit_cnt_d;
   logic [CFG_BITS-1:0]                cfg_shift_d;
   logic [CFG_BITS-1:0] cfg_word_q,    cfg_word_d;
   logic [DATA_W-1:0]   conv_q,        conv_d;
   logic                dout_q,        dout_d;
   logic                cfg_valid_q,   cfg_valid_d;
   logic                frame_error_q, frame_error_d;
   logic [15:0]         frame_count_q, frame_count_d;

   // Next-state logic for the frame FSM, serial shifter and frame results.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      cfg_shift_d   = cfg_shift_q;
      cfg_word_d    = cfg_word_q;
      conv_d        = conv_q;
      dout_d        = dout_q;
      frame_count_d = frame_count_q;
      cfg_valid_d   = 1'b0;
      frame_error_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            dout_d = 1'b0;
            if (cs_fall) begin
               // Present the MSB of the previous conversion before the
               // first SCLK rise.
               state_d   = ST_SHIFT;
               shift_d   = conv_q;
               dout_d    = conv_q[DATA_W-1];
               bit_cnt_d = '0;
            end
         end

         ST_SHIFT: begin
            if (cs_rise) begin
               // CS_N rise takes priority over an SCLK edge in the same clock.
               state_d = ST_IDLE;
               dout_d  = 1'b0;
               if (bit_cnt_q == CNT_FULL) begin
                  cfg_word_d    = cfg_shift_q;
                  conv_d        = conv_new;
                  cfg_valid_d   = 1'b1;
                  frame_count_d = frame_count_q + 16'd1;
               end else begin
                  frame_error_d = 1'b1;
               end
            end else if (bit_cnt_q != CNT_FULL) begin
               if (sclk_rise) begin
                  if (bit_cnt_q < CNT_CFG) begin
                     cfg_shift_d = {cfg_shift_q[CFG_BITS-2:0], din_s};
                  end
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
               end else if (sclk_fall) begin
                  shift_d = {shift_q[DATA_W-2:0], 1'b0};
                  dout_d  = shift_q[DATA_W-2];
               end
            end else begin
               // All bits delivered: hold DOUT low and ignore further SCLKs.
               dout_d = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            dout_d  = 1'b0;
         end
      endcase
   end

   // Register the frame FSM state, shifter and frame results.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         cfg_shift_q   <= RESET_CFG;
         cfg_word_q    <= RESET_CFG;
         conv_q        <= '0;
         dout_q        <= 1'b0;
         cfg_valid_q   <= 1'b0;
         frame_error_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         cfg_shift_q   <= cfg_shift_d;
         cfg_word_q    <= cfg_word_d;
         conv_q        <= conv_d;
         dout_q        <= dout_d;
         cfg_valid_q   <= cfg_valid_d;
         frame_error_q <= frame_error_d;
         frame_count_q <= frame_count_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign adc_dout    = dout_q;
   assign cfg_word    = cfg_word_q;
   assign cfg_valid   = cfg_valid_q;
   assign frame_error = frame_error_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ltc2308_responder.sv
// tb_ltc2308_responder
// Drives SPI frames into the LTC2308 responder as the ADA controller would.
// A reference model predicts each returned DOUT word and each
// cfg_valid/frame_error pulse. Two monitor processes pop those predictions
// and compare them with what the DUT presents.

module tb_ltc2308_responder;

   localparam int          SYNC_STAGES = 2;
   localparam int          DATA_W      = 12;
   localparam int          CFG_BITS    = 6;
   localparam logic [5:0]  RESET_CFG   = 6'b100010;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 adc_cs_n;
   logic                 adc_sclk;
   logic                 adc_din;
   logic                 adc_dout;
   logic [8*DATA_W-1:0]  ch_data;
   logic [CFG_BITS-1:0]  cfg_word;
   logic                 cfg_valid;
   logic                 frame_error;
   logic [15:0]          frame_count;

   ltc2308_responder #(
      .SYNC_STAGES (SYNC_STAGES),
      .DATA_W      (DATA_W),
      .CFG_BITS    (CFG_BITS),
      .RESET_CFG   (RESET_CFG)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .adc_cs_n    (adc_cs_n),
      .adc_sclk    (adc_sclk),
      .adc_din     (adc_din),
      .adc_dout    (adc_dout),
      .ch_data     (ch_data),
      .cfg_word    (cfg_word),
      .cfg_valid   (cfg_valid),
      .frame_error (frame_error),
      .frame_count (frame_count)
   );

   always #10 clock = ~clock;

   // Channel inputs, held constant while a frame is in flight
   logic [DATA_W-1:0] ch [8];
   for (genvar g = 0; g < 8; g++) begin : g_ch
      assign ch_data[g*DATA_W +: DATA_W] = ch[g];
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        err;
      logic [5:0]  cfg;
      logic [15:0] cnt;
   } ev_t;

   ev_t               ev_q[$];
   logic [DATA_W-1:0] exp_dout_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: the ADC's visible state after each completed frame
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] m_conv;
   logic [5:0]        m_cfg;
   logic [15:0]       m_count;

   function automatic logic [DATA_W-1:0] ref_conv(input logic [5:0] cfg);
      int n;
      if (cfg[5] == 1'b0 || cfg[1] == 1'b0) return '0;
      // O/S picks the odd channel of a pair; S0 and S1 pick the pair.
      n = 4 * int'(cfg[3]) + 2 * int'(cfg[2]) + int'(cfg[4]);
      return ch[n];
   endfunction

   task automatic model_reset();
      m_conv  = '0;
      m_cfg   = RESET_CFG;
      m_count = '0;
   endtask

   // ------------------------------------------------------------------
   // Monitors
   // ------------------------------------------------------------------
   // Collect DOUT on each SCLK rise and compare complete words at CS_N rise.
   initial begin : dout_mon
      int                nbits;
      logic [DATA_W-1:0] word;
      logic              aborted;
      logic [DATA_W-1:0] exp;
      forever begin
         @(negedge adc_cs_n);
         nbits   = 0;
         word    = '0;
         aborted = 1'b0;
         while (adc_cs_n == 1'b0) begin
            @(posedge adc_sclk or posedge adc_cs_n or posedge reset);
            if (reset) begin
               aborted = 1'b1;
            end else if (adc_cs_n == 1'b0 && nbits < DATA_W) begin
               word  = {word[DATA_W-2:0], adc_dout};
               nbits = nbits + 1;
            end
         end
         if (!aborted && nbits == DATA_W) begin
            check("dout_expected", 32'(exp_dout_q.size() != 0), 1);
            if (exp_dout_q.size() != 0) begin
               exp = exp_dout_q.pop_front();
               check("dout_word", word, exp);
            end
         end
      end
   end

   // Compare every cfg_valid/frame_error pulse against the predicted event.
   always @(negedge clock) begin
      ev_t e;
      if (!reset && (cfg_valid || frame_error)) begin
         check("ev_expected", 32'(ev_q.size() != 0), 1);
         if (ev_q.size() != 0) begin
            e = ev_q.pop_front();
            check("ev_cfg_valid",   cfg_valid,   !e.err);
            check("ev_frame_error", frame_error, e.err);
            check("ev_cfg_word",    cfg_word,    e.cfg);
            check("ev_frame_count", frame_count, e.cnt);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   // One controller frame: n_sclk SCLK pulses with half-period 'half' clocks.
   task automatic run_frame(input logic [5:0] cfg, input int n_sclk, input int half);
      ev_t e;
      if (n_sclk >= DATA_W) begin
         exp_dout_q.push_back(m_conv);
         m_conv  = ref_conv(cfg);
         m_cfg   = cfg;
         m_count = m_count + 16'd1;
         e.err   = 1'b0;
      end else begin
         e.err   = 1'b1;
      end
      e.cfg = m_cfg;
      e.cnt = m_count;
      ev_q.push_back(e);

      @(negedge clock);
      adc_din  = cfg[5];
      adc_cs_n = 1'b0;
      repeat (half) @(negedge clock);
      for (int i = 0; i < n_sclk; i++) begin
         adc_sclk = 1'b1;
         repeat (half) @(negedge clock);
         adc_sclk = 1'b0;
         adc_din  = (i + 1 < CFG_BITS) ? cfg[CFG_BITS-2-i] : 1'($urandom_range(0, 1));
         repeat (half) @(negedge clock);
      end
      adc_cs_n = 1'b1;
      repeat (half + SYNC_STAGES + 3) @(negedge clock);
      check("ev_drain",   ev_q.size(),       0);
      check("dout_drain", exp_dout_q.size(), 0);
   endtask

   task automatic set_ch_ramp(input logic [DATA_W-1:0] base);
      for (int c = 0; c < 8; c++) ch[c] = base + DATA_W'(c);
   endtask

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [5:0] cfg;
      int         nsclk;
      int         r;

      reset    = 1'b1;
      adc_cs_n = 1'b1;
      adc_sclk = 1'b0;
      adc_din  = 1'b0;
      for (int c = 0; c < 8; c++) ch[c] = '0;
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Reset state
      check("rst_dout",        adc_dout,    0);
      check("rst_cfg_word",    cfg_word,    RESET_CFG);
      check("rst_cfg_valid",   cfg_valid,   0);
      check("rst_frame_error", frame_error, 0);
      check("rst_frame_count", frame_count, 0);

      // First frame after reset returns zero, second returns CH0
      ch[0] = 12'hABC;
      run_frame(6'b100010, 12, 8);
      check("f1_cfg_word",    cfg_word,    6'b100010);
      check("f1_frame_count", frame_count, 1);
      run_frame(6'b100010, 12, 8);

      // Channel sweep with CHn = 0x100 + n
      set_ch_ramp(12'h100);
      run_frame(6'b100010, 12, 8);
      run_frame(6'b110010, 12, 8);
      run_frame(6'b100110, 12, 8);
      run_frame(6'b111110, 12, 8);
      run_frame(6'b100010, 12, 8);

      // Short frame: error pulse, then the prior conversion is still returned
      run_frame(6'b111010, 7, 8);
      check("short_cfg_word", cfg_word, 6'b100010);
      run_frame(6'b100010, 12, 8);

      // Differential mode converts as zero but is still latched
      ch[0] = 12'hFFF;
      run_frame(6'b000010, 12, 8);
      check("diff_cfg_word", cfg_word, 6'b000010);
      run_frame(6'b100010, 12, 8);

      // Minimum SCLK half period and extra SCLKs past the last bit
      run_frame(6'b101110, 12, 4);
      run_frame(6'b100010, 14, 4);

      // Reset mid-frame with CH7 = 0x555 latched
      ch[7] = 12'h555;
      run_frame(6'b111110, 12, 8);
      @(negedge clock);
      adc_din  = 1'b1;
      adc_cs_n = 1'b0;
      repeat (8) @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         adc_sclk = 1'b1;
         repeat (8) @(negedge clock);
         adc_sclk = 1'b0;
         repeat (8) @(negedge clock);
      end
      check("prereset_dout", adc_dout, m_conv[DATA_W-1-5]);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_dout",        adc_dout,    0);
      check("midrst_cfg_word",    cfg_word,    RESET_CFG);
      check("midrst_frame_count", frame_count, 0);
      model_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (8) @(negedge clock);
      adc_cs_n = 1'b1;
      repeat (8) @(negedge clock);
      check("postrst_no_event", 32'(cfg_valid | frame_error), 0);
      run_frame(6'b100010, 12, 8);

      // Randomised frames: configs, channel data, frame lengths, SCLK rates
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int c = 0; c < 8; c++) ch[c] = DATA_W'($urandom);
         end
         cfg = 6'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            cfg[5] = 1'b1;
            cfg[1] = 1'b1;
         end
         r = int'($urandom_range(0, 9));
         if (r == 0)      nsclk = int'($urandom_range(0, 11));
         else if (r == 1) nsclk = 12 + int'($urandom_range(1, 3));
         else             nsclk = 12;
         run_frame(cfg, nsclk, int'($urandom_range(4, 9)));
      end

      // Frame counter wrap from 16'hFFFF to 0
      @(negedge clock);
      force dut.frame_count_q = 16'hFFFF;
      repeat (3) @(negedge clock);
      release dut.frame_count_q;
      m_count = 16'hFFFF;
      @(negedge clock);
      check("count_preload", frame_count, 16'hFFFF);
      run_frame(6'b100010, 12, 6);
      check("count_wrap", frame_count, 0);

      repeat (10) @(negedge clock);
      check("final_ev_empty",   ev_q.size(),       0);
      check("final_dout_empty", exp_dout_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
